alu_pipe: RTL and testbench

Parametrised, pipelined signed/logical ALU; next generation of the team's 8-bit add/sub/and/or block. Adds configurable width, shift/XOR ops, per-transaction saturation mode, result flags, valid/ready handshakes on both sides, and sticky overflow status with an event counter. Sits between an operand-issuing front end and a result consumer that may apply backpressure.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_pipe_if.sv | 33 +++
 rtl/alu_core.sv | 62 ++++++
 rtl/alu_pipe.sv | 142 ++++++++++++++
 tb/tb_alu_pipe.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and the per-result flag bundle.
package alu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_ADD = 3'b000;
    localparam op_t OP_SUB = 3'b001;
    localparam op_t OP_AND = 3'b010;
    localparam op_t OP_OR  = 3'b011;
    localparam op_t OP_XOR = 3'b100;
    localparam op_t OP_SHL = 3'b101;
    localparam op_t OP_SHR = 3'b110;
    localparam op_t OP_ASR = 3'b111;

    // Flags travel with each result through the output stage.
    typedef struct packed {
        logic overflow;
        logic zero;
        logic neg;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result streaming bus for alu_pipe.
// Operand side: in_valid/in_ready handshake with a, b, op, sat.
// Result side:  out_valid/out_ready handshake with o and its flags.
// slave = ALU side, master = the front end / consumer side.
interface alu_pipe_if #(
    parameter int unsigned W = 8
);
    import alu_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    op_t          op;
    logic         sat;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] o;
    logic         overflow;
    logic         zero;
    logic         neg;

    modport slave (
        input  in_valid, a, b, op, sat, out_ready,
        output in_ready, out_valid, o, overflow, zero, neg
    );

    modport master (
        output in_valid, a, b, op, sat, out_ready,
        input  in_ready, out_valid, o, overflow, zero, neg
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: op select, signed overflow detect,
// optional saturation and result flags.
// Ports: a_i, b_i operands; op_i operation; sat_i saturate enable;
//        res_c_o final result; flags_c_o overflow/zero/neg of res_c_o.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  op_t          op_i,
    input  logic         sat_i,
    output logic [W-1:0] res_c_o,
    output alu_flags_t   flags_c_o
);
    localparam int unsigned SH_W = $clog2(W);

    logic [SH_W-1:0] sh_amt;
    logic [W-1:0]    sum;
    logic [W-1:0]    diff;
    logic [W-1:0]    raw;
    logic            ovf;
    logic [W-1:0]    sat_val;

    // Only the low log2(W) bits of b select the shift distance.
    assign sh_amt = b_i[SH_W-1:0];
    assign sum    = a_i + b_i;
    assign diff   = a_i - b_i;

    // Operation select and overflow detection.
    always_comb begin
        raw = '0;
        ovf = 1'b0;
        case (op_i)
            OP_ADD: begin
                raw = sum;
                ovf = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            OP_SUB: begin
                raw = diff;
                ovf = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
            end
            OP_AND:  raw = a_i & b_i;
            OP_OR:   raw = a_i | b_i;
            OP_XOR:  raw = a_i ^ b_i;
            OP_SHL:  raw = a_i << sh_amt;
            OP_SHR:  raw = a_i >> sh_amt;
            OP_ASR:  raw = W'($signed(a_i) >>> sh_amt);
            default: raw = '0;
        endcase
    end

    // Clamp toward the sign of a: max positive or min negative.
    assign sat_val = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    assign res_c_o = (sat_i && ovf) ? sat_val : raw;

    assign flags_c_o.overflow = ovf;
    assign flags_c_o.zero     = (res_c_o == '0);
    assign flags_c_o.neg      = res_c_o[W-1];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and sticky
// overflow status. S1 registers the operand beat, alu_core evaluates it,
// S2 registers the result and flags that drive the output bus.
// Ports: clk, rst (sync, active high); bus (alu_pipe_if.slave) operand and
//        result streams; clr_sticky clears status; ovf_sticky / ovf_count
//        report overflowing results that were accepted by the consumer.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_pipe_if.slave         bus,
    input  logic              clr_sticky,
    output logic              ovf_sticky,
    output logic [CNT_W-1:0]  ovf_count
);
    // S1: operand beat
    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_a_q, s1_a_d;
    logic [W-1:0] s1_b_q, s1_b_d;
    op_t          s1_op_q, s1_op_d;
    logic         s1_sat_q, s1_sat_d;

    // S2: result beat
    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] s2_o_q, s2_o_d;
    alu_flags_t   s2_flags_q, s2_flags_d;

    // Status
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Holds in_ready low for the first cycle after reset release.
    logic rdy_en_q;

    logic [W-1:0] core_res;
    alu_flags_t   core_flags;
    logic         s2_ready;
    logic         xfer_ovf;

    alu_core #(.W(W)) u_core (
        .a_i       (s1_a_q),
        .b_i       (s1_b_q),
        .op_i      (s1_op_q),
        .sat_i     (s1_sat_q),
        .res_c_o   (core_res),
        .flags_c_o (core_flags)
    );

    // Ready chain depends only on register state and out_ready, never in_valid.
    assign s2_ready     = !s2_valid_q || bus.out_ready;
    assign bus.in_ready = !rst && rdy_en_q && (!s1_valid_q || s2_ready);
    assign xfer_ovf     = s2_valid_q && bus.out_ready && s2_flags_q.overflow;

    // Next-state logic for both stages and status.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_sat_d   = s1_sat_q;
        s2_valid_d = s2_valid_q;
        s2_o_d     = s2_o_q;
        s2_flags_d = s2_flags_q;
        sticky_d   = sticky_q;
        count_d    = count_q;

        // in_ready implies S1 is empty or draining into S2 this cycle.
        if (bus.in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d   = bus.a;
                s1_b_d   = bus.b;
                s1_op_d  = bus.op;
                s1_sat_d = bus.sat;
            end
        end

        // Result registers only load on a real beat so o stays put otherwise.
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_o_d     = core_res;
                s2_flags_d = core_flags;
            end
        end

        // An overflowing transfer wins over a coincident clear (count restarts at 1).
        if (xfer_ovf) begin
            sticky_d = 1'b1;
            if (clr_sticky) begin
                count_d = CNT_W'(1);
            end else if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_en_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_ADD;
            s1_sat_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_o_q     <= '0;
            s2_flags_q <= '0;
            sticky_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            rdy_en_q   <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s1_sat_q   <= s1_sat_d;
            s2_valid_q <= s2_valid_d;
            s2_o_q     <= s2_o_d;
            s2_flags_q <= s2_flags_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.o         = s2_o_q;
    assign bus.overflow  = s2_flags_q.overflow;
    assign bus.zero      = s2_flags_q.zero;
    assign bus.neg       = s2_flags_q.neg;
    assign ovf_sticky    = sticky_q;
    assign ovf_count     = count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (W=8, CNT_W=2) with hand-computed expectations.
module tb_alu_pipe;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       sat;
        logic [7:0] o;
        logic       ovf;
        logic       z;
        logic       n;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_sticky;
    logic       ovf_sticky;
    logic [1:0] ovf_count;

    int total = 0;
    int bad   = 0;

    alu_pipe_if #(.W(8)) bus ();

    alu_pipe #(.W(8), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    // Streamed beats: a, b, op, sat -> o, overflow, zero, neg
    vec_t strm [10] = '{
        '{8'h10, 8'h20, OP_ADD, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0},
        '{8'h10, 8'h20, OP_SUB, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1},
        '{8'hF0, 8'h3C, OP_AND, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0},
        '{8'h0F, 8'h30, OP_OR,  1'b0, 8'h3F, 1'b0, 1'b0, 1'b0},
        '{8'hFF, 8'hFF, OP_XOR, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0},
        '{8'h81, 8'h0B, OP_SHL, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0},
        '{8'h81, 8'h01, OP_SHR, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0},
        '{8'h81, 8'h01, OP_ASR, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b1},
        '{8'h80, 8'h80, OP_ADD, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0},
        '{8'h7F, 8'hFF, OP_SUB, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0}
    };

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_beat(input vec_t v);
        bus.a   = v.a;
        bus.b   = v.b;
        bus.op  = v.op;
        bus.sat = v.sat;
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, "_o"},    32'(bus.o),        32'(v.o));
        chk({tag, "_ovf"},  32'(bus.overflow), 32'(v.ovf));
        chk({tag, "_zero"}, 32'(bus.zero),     32'(v.z));
        chk({tag, "_neg"},  32'(bus.neg),      32'(v.n));
    endtask

    // One isolated beat: accept, verify 2-cycle latency, transfer with optional clear.
    task automatic run_one(input string tag, input vec_t v, input logic clr);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        drive_beat(v);
        #1 chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        chk_result(tag, v);
        clr_sticky = clr;
        @(posedge clk);
        @(negedge clk);
        clr_sticky = 1'b0;
    endtask

    initial begin
        int   si;
        int   ri;
        logic acc;
        logic xf;

        rst           = 1'b1;
        clr_sticky    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = OP_ADD;
        bus.sat       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_o",         32'(bus.o),         32'd0);
        chk("rst_flags",     32'({bus.overflow, bus.zero, bus.neg}), 32'd0);
        chk("rst_sticky",    32'(ovf_sticky),    32'd0);
        chk("rst_count",     32'(ovf_count),     32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed single beats with status tracking (2-bit counter)
        run_one("add_wrap", '{8'h7F, 8'h01, OP_ADD, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1}, 1'b0);
        chk("cnt_after1", 32'(ovf_count), 32'd1);
        chk("sticky_after1", 32'(ovf_sticky), 32'd1);
        run_one("add_sat", '{8'h7F, 8'h01, OP_ADD, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0}, 1'b0);
        run_one("sub_sat", '{8'h80, 8'h01, OP_SUB, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1}, 1'b0);
        chk("cnt_after3", 32'(ovf_count), 32'd3);
        run_one("sub_zero", '{8'h05, 8'h05, OP_SUB, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}, 1'b0);
        run_one("asr",      '{8'h90, 8'h0A, OP_ASR, 1'b0, 8'hE4, 1'b0, 1'b0, 1'b1}, 1'b0);
        run_one("shr",      '{8'h90, 8'h0A, OP_SHR, 1'b0, 8'h24, 1'b0, 1'b0, 1'b0}, 1'b0);
        run_one("xor",      '{8'hF0, 8'h3C, OP_XOR, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b1}, 1'b0);
        run_one("add_neg",  '{8'h80, 8'h80, OP_ADD, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0}, 1'b0);
        run_one("add_pos",  '{8'h40, 8'h40, OP_ADD, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1}, 1'b0);
        chk("cnt_sat5", 32'(ovf_count), 32'd3);
        chk("sticky_sat5", 32'(ovf_sticky), 32'd1);

        // Clear coincident with an overflowing transfer restarts at 1
        run_one("clr_ovf", '{8'h40, 8'h40, OP_ADD, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1}, 1'b1);
        chk("clr_ovf_count",  32'(ovf_count),  32'd1);
        chk("clr_ovf_sticky", 32'(ovf_sticky), 32'd1);

        // Clear alone
        clr_sticky = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("clr_count",  32'(ovf_count),  32'd0);
        chk("clr_sticky", 32'(ovf_sticky), 32'd0);

        // Back-to-back stream with a 3-cycle consumer stall
        si = 0;
        ri = 0;
        for (int cyc = 0; cyc < 40 && ri < 10; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 4 && cyc <= 6);
            if (si < 10) begin
                bus.in_valid = 1'b1;
                drive_beat(strm[si]);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (!bus.out_ready) begin
                chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
                chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            end
            if (bus.out_valid) begin
                chk_result($sformatf("strm%0d", ri), strm[ri]);
            end
            acc = bus.in_valid && bus.in_ready;
            xf  = bus.out_valid && bus.out_ready;
            @(posedge clk);
            if (acc) si++;
            if (xf)  ri++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("strm_all_out", 32'(ri), 32'd10);
        chk("strm_all_in",  32'(si), 32'd10);
        chk("strm_drained", 32'(bus.out_valid), 32'd0);
        chk("strm_count",   32'(ovf_count),  32'd2);
        chk("strm_sticky",  32'(ovf_sticky), 32'd1);

        // Fill both stages under backpressure, then reset
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive_beat(strm[8]);
        @(posedge clk);
        @(negedge clk);
        drive_beat(strm[9]);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_in_ready",  32'(bus.in_ready),  32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_count",     32'(ovf_count),     32'd0);
        chk("mid_rst_sticky",    32'(ovf_sticky),    32'd0);
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_stale_beat", 32'(bus.out_valid), 32'd0);
        end
        chk("mid_rst_ready_back", 32'(bus.in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
